// File: rtl/mips_ctrl_pkg.sv
// Shared decode constants for the MIPS controllers: opcodes, funcs, ALU codes,
// instruction classes, FSM state codes and datapath mux encodings.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_SLLV = 6'b000100;
   localparam logic [5:0] FN_SRLV = 6'b000110;
   localparam logic [5:0] FN_SRAV = 6'b000111;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLTU = 6'b101011;

   typedef enum logic [3:0] {
      ALU_AND = 4'd0, ALU_OR = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3,
      ALU_SLT = 4'd4, ALU_NOR = 4'd5, ALU_XOR = 4'd6, ALU_LUI = 4'd7,
      ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_SLLV = 4'd11,
      ALU_SRLV = 4'd12, ALU_SRAV = 4'd13, ALU_SLTU = 4'd14
   } alu_op_e;

   typedef enum logic [3:0] {
      CLS_R_ALU, CLS_I_ALU, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE,
      CLS_J, CLS_JAL, CLS_JR, CLS_ILL
   } instr_cls_e;

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_EXEC_R   = 4'd2;
   localparam logic [3:0] S_EXEC_I   = 4'd3;
   localparam logic [3:0] S_WB_R     = 4'd4;
   localparam logic [3:0] S_WB_I     = 4'd5;
   localparam logic [3:0] S_MEM_ADDR = 4'd6;
   localparam logic [3:0] S_MEM_RD   = 4'd7;
   localparam logic [3:0] S_MEM_WB   = 4'd8;
   localparam logic [3:0] S_MEM_WR   = 4'd9;
   localparam logic [3:0] S_BRANCH   = 4'd10;
   localparam logic [3:0] S_JUMP     = 4'd11;
   localparam logic [3:0] S_JAL      = 4'd12;
   localparam logic [3:0] S_JR       = 4'd13;
   localparam logic [3:0] S_ILLEGAL  = 4'd14;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_RS     = 2'b11;
   localparam logic [1:0] REGDST_RT    = 2'b00;
   localparam logic [1:0] REGDST_RD    = 2'b01;
   localparam logic [1:0] REGDST_RA    = 2'b10;
   localparam logic [1:0] M2R_ALUOUT   = 2'b00;
   localparam logic [1:0] M2R_MDR      = 2'b01;
   localparam logic [1:0] M2R_PC       = 2'b10;
   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH  = 2'b11;

endpackage

// File: rtl/mips_mc_controller_if.sv
// Controller <-> datapath/memory bundle. master = controller, slave = datapath side.
interface mips_mc_controller_if #(
   parameter int ALUOP_W = 4,
   parameter int CNT_W   = 32
);
   logic [5:0]         opcode;
   logic [5:0]         func;
   logic               alu_zero;
   logic               mem_ready;
   logic               mem_read;
   logic               mem_write;
   logic               iord;
   logic               ir_write;
   logic               pc_en;
   logic [1:0]         pc_src;
   logic               reg_write;
   logic [1:0]         reg_dst;
   logic [1:0]         mem_to_reg;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic [ALUOP_W-1:0] alu_op;
   logic               signed_imm;
   logic               illegal_instr;
   logic [CNT_W-1:0]   retired;

   modport master (
      input  opcode, func, alu_zero, mem_ready,
      output mem_read, mem_write, iord, ir_write, pc_en, pc_src, reg_write,
             reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, signed_imm,
             illegal_instr, retired
   );

   modport slave (
      output opcode, func, alu_zero, mem_ready,
      input  mem_read, mem_write, iord, ir_write, pc_en, pc_src, reg_write,
             reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, signed_imm,
             illegal_instr, retired
   );
endinterface

// File: rtl/mips_alu_dec.sv
// Combinational instruction decode: opcode/func to ALU op, immediate extension,
// instruction class and legality.
module mips_alu_dec
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] func,
   output alu_op_e    alu_op,
   output logic       signed_imm,
   output instr_cls_e cls,
   output logic       legal
);
   always_comb begin
      alu_op     = ALU_ADD;
      signed_imm = 1'b0;
      cls        = CLS_ILL;
      legal      = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            cls = CLS_R_ALU;
            case (func)
               FN_ADD, FN_ADDU: alu_op = ALU_ADD;
               FN_SUB, FN_SUBU: alu_op = ALU_SUB;
               FN_SLT:          alu_op = ALU_SLT;
               FN_SLTU:         alu_op = ALU_SLTU;
               FN_AND:          alu_op = ALU_AND;
               FN_OR:           alu_op = ALU_OR;
               FN_XOR:          alu_op = ALU_XOR;
               FN_NOR:          alu_op = ALU_NOR;
               FN_SLL:          alu_op = ALU_SLL;
               FN_SRL:          alu_op = ALU_SRL;
               FN_SRA:          alu_op = ALU_SRA;
               FN_SLLV:         alu_op = ALU_SLLV;
               FN_SRLV:         alu_op = ALU_SRLV;
               FN_SRAV:         alu_op = ALU_SRAV;
               FN_JR:           cls    = CLS_JR;
               default: begin
                  cls   = CLS_ILL;
                  legal = 1'b0;
               end
            endcase
         end
         OP_ADDI, OP_ADDIU: begin cls = CLS_I_ALU; alu_op = ALU_ADD;  signed_imm = 1'b1; end
         OP_SLTI:           begin cls = CLS_I_ALU; alu_op = ALU_SLT;  signed_imm = 1'b1; end
         OP_SLTIU:          begin cls = CLS_I_ALU; alu_op = ALU_SLTU; signed_imm = 1'b1; end
         OP_ANDI:           begin cls = CLS_I_ALU; alu_op = ALU_AND; end
         OP_ORI:            begin cls = CLS_I_ALU; alu_op = ALU_OR;  end
         OP_XORI:           begin cls = CLS_I_ALU; alu_op = ALU_XOR; end
         OP_LUI:            begin cls = CLS_I_ALU; alu_op = ALU_LUI; end
         OP_LW:             begin cls = CLS_LW;  signed_imm = 1'b1; end
         OP_SW:             begin cls = CLS_SW;  signed_imm = 1'b1; end
         OP_BEQ:            begin cls = CLS_BEQ; alu_op = ALU_SUB; signed_imm = 1'b1; end
         OP_BNE:            begin cls = CLS_BNE; alu_op = ALU_SUB; signed_imm = 1'b1; end
         OP_J:              cls = CLS_J;
         OP_JAL:            cls = CLS_JAL;
         default: begin
            cls   = CLS_ILL;
            legal = 1'b0;
         end
      endcase
   end
endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// over a shared ALU and memory port, and counts retired legal instructions.
module mips_mc_controller
   import mips_ctrl_pkg::*;
#(
   parameter int ALUOP_W = 4,
   parameter int CNT_W   = 32
) (
   input logic                  clk,
   input logic                  rst,
   mips_mc_controller_if.master bus
);
   logic [3:0]       state, next;
   logic [CNT_W-1:0] count;
   alu_op_e          dec_op;
   instr_cls_e       cls;
   logic             dec_sgn, dec_legal;

   logic       mem_read, mem_write, iord, ir_write, reg_write, src_a, illegal, sgn;
   logic       pc_write, pc_write_cond, branch_ne, retire;
   logic [1:0] pc_src, reg_dst, mem_to_reg, src_b;
   logic [3:0] op4;

   mips_alu_dec u_dec (
      .opcode     (bus.opcode),
      .func       (bus.func),
      .alu_op     (dec_op),
      .signed_imm (dec_sgn),
      .cls        (cls),
      .legal      (dec_legal)
   );

   always_comb begin
      next          = state;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      src_a         = 1'b0;
      illegal       = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      retire        = 1'b0;
      pc_src        = PCSRC_ALU;
      reg_dst       = REGDST_RT;
      mem_to_reg    = M2R_ALUOUT;
      src_b         = SRCB_RT;
      op4           = ALU_AND;
      // IR is only meaningful once loaded, so extension mode is suppressed in FETCH
      sgn           = (state != S_FETCH) && dec_sgn;
      case (state)
         S_FETCH: begin
            mem_read = 1'b1;
            src_b    = SRCB_FOUR;
            op4      = ALU_ADD;
            if (bus.mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               next     = S_DECODE;
            end
         end
         S_DECODE: begin
            src_b = SRCB_IMM_SH;
            op4   = ALU_ADD;
            if (!dec_legal) next = S_ILLEGAL;
            else begin
               case (cls)
                  CLS_R_ALU:      next = S_EXEC_R;
                  CLS_I_ALU:      next = S_EXEC_I;
                  CLS_LW, CLS_SW: next = S_MEM_ADDR;
                  CLS_BEQ,
                  CLS_BNE:        next = S_BRANCH;
                  CLS_J:          next = S_JUMP;
                  CLS_JAL:        next = S_JAL;
                  CLS_JR:         next = S_JR;
                  default:        next = S_ILLEGAL;
               endcase
            end
         end
         S_EXEC_R:   begin src_a = 1'b1; src_b = SRCB_RT;  op4 = dec_op; next = S_WB_R; end
         S_EXEC_I:   begin src_a = 1'b1; src_b = SRCB_IMM; op4 = dec_op; next = S_WB_I; end
         S_WB_R:     begin reg_write = 1'b1; reg_dst = REGDST_RD; retire = 1'b1; next = S_FETCH; end
         S_WB_I:     begin reg_write = 1'b1; retire = 1'b1; next = S_FETCH; end
         S_MEM_ADDR: begin
            src_a = 1'b1;
            src_b = SRCB_IMM;
            op4   = ALU_ADD;
            next  = (cls == CLS_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (bus.mem_ready) next = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = M2R_MDR;
            retire     = 1'b1;
            next       = S_FETCH;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (bus.mem_ready) begin
               retire = 1'b1;
               next   = S_FETCH;
            end
         end
         S_BRANCH: begin
            src_a         = 1'b1;
            op4           = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_src        = PCSRC_ALUOUT;
            branch_ne     = (cls == CLS_BNE);
            retire        = 1'b1;
            next          = S_FETCH;
         end
         S_JUMP: begin pc_write = 1'b1; pc_src = PCSRC_JUMP; retire = 1'b1; next = S_FETCH; end
         S_JAL: begin
            pc_write   = 1'b1;
            pc_src     = PCSRC_JUMP;
            reg_write  = 1'b1;
            reg_dst    = REGDST_RA;
            mem_to_reg = M2R_PC;
            retire     = 1'b1;
            next       = S_FETCH;
         end
         S_JR:      begin pc_write = 1'b1; pc_src = PCSRC_RS; retire = 1'b1; next = S_FETCH; end
         S_ILLEGAL: begin illegal = 1'b1; next = S_FETCH; end
         default:   next = S_FETCH;
      endcase
      // Reset silences every control line in the same cycle, aborting any wait
      if (rst) begin
         mem_read = 1'b0; mem_write = 1'b0; iord = 1'b0; ir_write = 1'b0;
         reg_write = 1'b0; src_a = 1'b0; illegal = 1'b0; sgn = 1'b0;
         pc_write = 1'b0; pc_write_cond = 1'b0; branch_ne = 1'b0; retire = 1'b0;
         pc_src = 2'b00; reg_dst = 2'b00; mem_to_reg = 2'b00; src_b = 2'b00;
         op4 = 4'b0000;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
         count <= '0;
      end else begin
         state <= next;
         if (retire) count <= count + 1'b1;
      end
   end

   assign bus.mem_read      = mem_read;
   assign bus.mem_write     = mem_write;
   assign bus.iord          = iord;
   assign bus.ir_write      = ir_write;
   assign bus.pc_en         = pc_write | (pc_write_cond & (bus.alu_zero ^ branch_ne));
   assign bus.pc_src        = pc_src;
   assign bus.reg_write     = reg_write;
   assign bus.reg_dst       = reg_dst;
   assign bus.mem_to_reg    = mem_to_reg;
   assign bus.alu_src_a     = src_a;
   assign bus.alu_src_b     = src_b;
   assign bus.alu_op        = ALUOP_W'(op4);
   assign bus.signed_imm    = sgn;
   assign bus.illegal_instr = illegal;
   assign bus.retired       = count;
endmodule

// File: tb/tb_mips_mc_controller.sv
// Randomized scoreboard bench for mips_mc_controller: each issued instruction
// expands into per-cycle expected control vectors checked by a monitor.
module tb_mips_mc_controller;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mips_mc_controller_if #(.ALUOP_W(4), .CNT_W(32)) bus ();
   mips_mc_controller #(.ALUOP_W(4), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   localparam int B_MRD = 0, B_MWR = 1, B_IORD = 2, B_IRW = 3, B_PCEN = 4, B_PCSRC = 5;
   localparam int B_RW = 7, B_DST = 8, B_M2R = 10, B_SA = 12, B_SB = 13, B_OP = 15;
   localparam int B_SGN = 19, B_ILL = 20;
   localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_BNE = 5;
   localparam int C_J = 6, C_JAL = 7, C_JR = 8, C_ILL = 9;

   typedef logic [20:0] vec_t;
   // single-bit enables must be low unless the cycle asserts them
   localparam vec_t EN_MASK = vec_t'((1 << B_MRD) | (1 << B_MWR) | (1 << B_IRW) |
                                     (1 << B_PCEN) | (1 << B_RW) | (1 << B_ILL));

   typedef struct {
      vec_t        v;
      vec_t        m;
      logic [31:0] ret;
      bit          ret_chk;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   errors = 0, checks = 0;
   int   model_cnt = 0;
   vec_t ev, em;
   int   cyc_i, rst_at;
   bit   aborted;
   exp_t me;
   vec_t ma;

   logic [5:0] OPS [16] = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d,
                            6'h0e, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03};
   logic [5:0] FNS [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h2a, 6'h2b, 6'h24, 6'h25, 6'h26,
                            6'h27, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};

   // Reference decode table written straight from the instruction list
   function automatic void ref_decode(input logic [5:0] opc, input logic [5:0] fn,
                                      output int cls, output int aop, output bit sgn);
      cls = C_ILL; aop = 0; sgn = 1'b0;
      case (opc)
         6'h00: case (fn)
            6'h20, 6'h21: begin cls = C_R; aop = 2; end
            6'h22, 6'h23: begin cls = C_R; aop = 3; end
            6'h2a: begin cls = C_R; aop = 4;  end
            6'h2b: begin cls = C_R; aop = 14; end
            6'h24: begin cls = C_R; aop = 0;  end
            6'h25: begin cls = C_R; aop = 1;  end
            6'h26: begin cls = C_R; aop = 6;  end
            6'h27: begin cls = C_R; aop = 5;  end
            6'h00: begin cls = C_R; aop = 8;  end
            6'h02: begin cls = C_R; aop = 9;  end
            6'h03: begin cls = C_R; aop = 10; end
            6'h04: begin cls = C_R; aop = 11; end
            6'h06: begin cls = C_R; aop = 12; end
            6'h07: begin cls = C_R; aop = 13; end
            6'h08: cls = C_JR;
            default: cls = C_ILL;
         endcase
         6'h08, 6'h09: begin cls = C_I; aop = 2;  sgn = 1'b1; end
         6'h0a:        begin cls = C_I; aop = 4;  sgn = 1'b1; end
         6'h0b:        begin cls = C_I; aop = 14; sgn = 1'b1; end
         6'h0c:        begin cls = C_I; aop = 0; end
         6'h0d:        begin cls = C_I; aop = 1; end
         6'h0e:        begin cls = C_I; aop = 6; end
         6'h0f:        begin cls = C_I; aop = 7; end
         6'h23:        begin cls = C_LW;  sgn = 1'b1; end
         6'h2b:        begin cls = C_SW;  sgn = 1'b1; end
         6'h04:        begin cls = C_BEQ; sgn = 1'b1; end
         6'h05:        begin cls = C_BNE; sgn = 1'b1; end
         6'h02:        cls = C_J;
         6'h03:        cls = C_JAL;
         default:      cls = C_ILL;
      endcase
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic void new_cycle();
      ev = '0;
      em = EN_MASK;
   endfunction

   function automatic void fld(input int lsb, input int w, input int val);
      for (int i = 0; i < w; i++) begin
         ev[lsb+i] = val[i];
         em[lsb+i] = 1'b1;
      end
   endfunction

   function automatic vec_t sample();
      vec_t a = '0;
      a[B_MRD] = bus.mem_read;       a[B_MWR] = bus.mem_write;
      a[B_IORD] = bus.iord;          a[B_IRW] = bus.ir_write;
      a[B_PCEN] = bus.pc_en;         a[B_PCSRC+:2] = bus.pc_src;
      a[B_RW] = bus.reg_write;       a[B_DST+:2] = bus.reg_dst;
      a[B_M2R+:2] = bus.mem_to_reg;  a[B_SA] = bus.alu_src_a;
      a[B_SB+:2] = bus.alu_src_b;    a[B_OP+:4] = bus.alu_op;
      a[B_SGN] = bus.signed_imm;     a[B_ILL] = bus.illegal_instr;
      return a;
   endfunction

   task automatic tick(input string tag, input logic rdy, input logic z, input bit do_rst);
      exp_t e;
      rst = do_rst;
      bus.mem_ready = rdy;
      bus.alu_zero = z;
      e.v = do_rst ? '0 : ev;
      e.m = do_rst ? '1 : em;
      e.ret = model_cnt;
      e.ret_chk = !do_rst;
      e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string tag, input logic rdy, input logic z);
      if (cyc_i == rst_at) begin
         tick(tag, rdy, z, 1'b1);
         model_cnt = 0;
         aborted = 1'b1;
      end else tick(tag, rdy, z, 1'b0);
      cyc_i++;
   endtask

   // One instruction: wf/wm = not-ready cycles in fetch/memory, zf forces alu_zero
   // in BRANCH (-1 random), rat = cycle index at which reset is asserted (-1 none).
   task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input int wf,
                            input int wm, input int zf, input int rat);
      int cls, aop;
      bit sgn;
      logic z;
      ref_decode(opc, fn, cls, aop, sgn);
      cyc_i = 0; rst_at = rat; aborted = 1'b0;
      bus.opcode = opc; bus.func = fn;
      for (int k = 0; k < wf; k++) begin
         new_cycle(); ev[B_MRD] = 1'b1; fld(B_IORD, 1, 0);
         step("fetch_wait", 1'b0, rb()); if (aborted) return;
      end
      new_cycle(); ev[B_MRD] = 1'b1; ev[B_IRW] = 1'b1; ev[B_PCEN] = 1'b1;
      fld(B_IORD, 1, 0); fld(B_SA, 1, 0); fld(B_SB, 2, 1); fld(B_OP, 4, 2); fld(B_PCSRC, 2, 0);
      step("fetch", 1'b1, rb()); if (aborted) return;
      new_cycle(); fld(B_SA, 1, 0); fld(B_SB, 2, 3); fld(B_OP, 4, 2); fld(B_SGN, 1, int'(sgn));
      step("decode", rb(), rb()); if (aborted) return;
      case (cls)
         C_R, C_I: begin
            new_cycle(); fld(B_SA, 1, 1); fld(B_SB, 2, (cls == C_R) ? 0 : 2); fld(B_OP, 4, aop);
            if (cls == C_I) fld(B_SGN, 1, int'(sgn));
            step("exec", rb(), rb()); if (aborted) return;
            new_cycle(); ev[B_RW] = 1'b1; fld(B_M2R, 2, 0); fld(B_DST, 2, (cls == C_R) ? 1 : 0);
            step("wb", rb(), rb());
         end
         C_LW, C_SW: begin
            new_cycle(); fld(B_SA, 1, 1); fld(B_SB, 2, 2); fld(B_OP, 4, 2);
            step("mem_addr", rb(), rb()); if (aborted) return;
            for (int k = 0; k <= wm; k++) begin
               new_cycle(); fld(B_IORD, 1, 1);
               if (cls == C_LW) ev[B_MRD] = 1'b1; else ev[B_MWR] = 1'b1;
               step((cls == C_LW) ? "mem_rd" : "mem_wr", (k == wm), rb()); if (aborted) return;
            end
            if (cls == C_LW) begin
               new_cycle(); ev[B_RW] = 1'b1; fld(B_M2R, 2, 1); fld(B_DST, 2, 0);
               step("mem_wb", rb(), rb());
            end
         end
         C_BEQ, C_BNE: begin
            z = (zf < 0) ? rb() : zf[0];
            new_cycle(); fld(B_SA, 1, 1); fld(B_SB, 2, 0); fld(B_OP, 4, 3); fld(B_PCSRC, 2, 1);
            ev[B_PCEN] = (cls == C_BNE) ? ~z : z;
            step("branch", rb(), z);
         end
         C_J: begin
            new_cycle(); ev[B_PCEN] = 1'b1; fld(B_PCSRC, 2, 2);
            step("jump", rb(), rb());
         end
         C_JAL: begin
            new_cycle(); ev[B_PCEN] = 1'b1; ev[B_RW] = 1'b1;
            fld(B_PCSRC, 2, 2); fld(B_DST, 2, 2); fld(B_M2R, 2, 2);
            step("jal", rb(), rb());
         end
         C_JR: begin
            new_cycle(); ev[B_PCEN] = 1'b1; fld(B_PCSRC, 2, 3);
            step("jr", rb(), rb());
         end
         default: begin
            new_cycle(); ev[B_ILL] = 1'b1;
            step("illegal", rb(), rb());
            return;
         end
      endcase
      if (aborted) return;
      model_cnt++;
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         me = sb.pop_front();
         ma = sample();
         checks++;
         if ((ma & me.m) !== (me.v & me.m)) begin
            errors++;
            $display("FAIL %s ctrl t=%0t got=%h want=%h care=%h", me.tag, $time,
                     ma & me.m, me.v & me.m, me.m);
         end
         if (me.ret_chk) begin
            checks++;
            if (bus.retired !== me.ret) begin
               errors++;
               $display("FAIL %s retired t=%0t got=%0d want=%0d", me.tag, $time,
                        bus.retired, me.ret);
            end
         end
      end
   end

   initial begin
      logic [5:0] opc, fn;
      int rat;
      bus.opcode = 6'h00; bus.func = 6'h00; bus.mem_ready = 1'b0; bus.alu_zero = 1'b0;
      @(posedge clk); #1;
      new_cycle();
      for (int i = 0; i < 3; i++) tick("reset", rb(), rb(), 1'b1);
      model_cnt = 0;

      run_instr(6'h00, 6'h20, 0, 0, -1, -1);   // add $3,$1,$2
      run_instr(6'h23, 6'h00, 2, 2, -1, -1);   // lw with two-cycle waits
      run_instr(6'h05, 6'h00, 0, 0, 0, -1);    // bne, not equal -> taken
      run_instr(6'h04, 6'h00, 0, 0, 0, -1);    // beq, not equal -> not taken
      run_instr(6'h0b, 6'h00, 1, 0, -1, -1);   // sltiu
      run_instr(6'h0d, 6'h00, 0, 0, -1, -1);   // ori
      run_instr(6'h03, 6'h00, 0, 0, -1, -1);   // jal
      run_instr(6'h00, 6'h08, 0, 0, -1, -1);   // jr
      run_instr(6'h3f, 6'h00, 0, 0, -1, -1);   // illegal opcode
      run_instr(6'h2b, 6'h00, 0, 3, -1, 4);    // sw, reset during write wait
      run_instr(6'h02, 6'h00, 0, 0, -1, -1);   // j straight after reset

      for (int n = 0; n < 400; n++) begin
         opc = ($urandom_range(0, 9) == 0) ? 6'($urandom) : OPS[$urandom_range(0, 15)];
         fn  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : FNS[$urandom_range(0, 16)];
         rat = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 7)) : -1;
         run_instr(opc, fn, $urandom_range(0, 2), $urandom_range(0, 2), -1, rat);
      end

      @(negedge clk);
      @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d want=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multi-cycle control unit for the next-generation MIPS core. It replaces the purely combinational single-cycle decoder with a state machine that sequences fetch, decode, execute, memory and write-back over several cycles through one shared ALU and one shared memory port, stalling on a memory ready handshake. It also adds unsigned-compare decode, illegal-instruction detection and a retired-instruction counter. It sits between the instruction register (opcode/func fields) and the multi-cycle datapath.

## Interface
Parameters:
- ALUOP_W, 4: ALU operation width; must be ≥ 4, codes zero-extended.
- CNT_W, 32: retired-instruction counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- func  in  6  IR[5:0].
- alu_zero  in  1  ALU zero flag, same cycle.
- mem_ready  in  1  memory completes the current read/write this cycle.
- mem_read, mem_write  out  1  memory request; held until mem_ready.
- iord  out  1  0 = PC address, 1 = ALUOut address.
- ir_write  out  1  load IR.
- pc_en  out  1  = pc_write | (pc_write_cond & (alu_zero ^ branch_ne)).
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs.
- reg_write  out  1  register-file write.
- reg_dst  out  2  00 rt, 01 rd, 10 $31.
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC.
- alu_src_a  out  1  0 PC, 1 rs.
- alu_src_b  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2.
- alu_op  out  ALUOP_W  operation code.
- signed_imm  out  1  1 sign-extend, 0 zero-extend.
- illegal_instr  out  1  one-cycle pulse on unsupported opcode/func.
- retired  out  CNT_W  count of completed legal instructions.

## Operation
- ALU codes: 0000 and, 0001 or, 0010 add, 0011 sub, 0100 slt, 0101 nor, 0110 xor, 0111 lui, 1000 sll, 1001 srl, 1010 sra, 1011 sllv, 1100 srlv, 1101 srav, 1110 sltu (new; used by sltu and sltiu).
- R-type funcs: add/addu→add, sub/subu→sub, slt, sltu, and, or, xor, nor, the six shifts, jr (001000). Any other func is illegal.
- I-type and jump opcodes: addi, addiu, slti, sltiu, andi, ori, xori, lui, lw, sw, beq, bne, j, jal. Any other opcode is illegal.
- signed_imm = 1 for addi, addiu, slti, sltiu, lw, sw, beq, bne; 0 otherwise.
- States and transitions:
  - FETCH: mem_read, iord=0. While !mem_ready, stay. On mem_ready: ir_write, pc_write, alu PC+4 (src_a=0, src_b=01, add, pc_src=00), go to DECODE.
  - DECODE: ALU computes PC+(imm<<2) (src_b=11, add). Dispatch: R-ALU→EXEC_R; I-ALU→EXEC_I; lw/sw→MEM_ADDR; beq/bne→BRANCH; j→JUMP; jal→JAL; jr→JR; illegal→ILLEGAL.
  - EXEC_R: src_a=1, src_b=00, decoded op → WB_R.
  - EXEC_I: src_a=1, src_b=10, decoded op → WB_I.
  - WB_R / WB_I: reg_write, mem_to_reg=00, reg_dst 01 / 00 → FETCH.
  - MEM_ADDR: src_a=1, src_b=10, add → MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD: mem_read, iord=1; wait for mem_ready → MEM_WB.
  - MEM_WB: reg_write, mem_to_reg=01, reg_dst=00 → FETCH.
  - MEM_WR: mem_write, iord=1; wait for mem_ready → FETCH.
  - BRANCH: src_a=1, src_b=00, sub, pc_write_cond, pc_src=01, branch_ne=(bne) → FETCH.
  - JUMP: pc_write, pc_src=10 → FETCH.
  - JAL: pc_write, pc_src=10, reg_write, reg_dst=10, mem_to_reg=10 → FETCH.
  - JR: pc_write, pc_src=11 → FETCH.
  - ILLEGAL: illegal_instr=1 → FETCH. No register, memory or counter update.
- retired increments by 1, wrapping mod 2^CNT_W, in the final cycle of each legal instruction: WB_R, WB_I, MEM_WB, MEM_WR with mem_ready, BRANCH (taken or not), JUMP, JAL, JR.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.

## Timing
- Control outputs are combinational from the state register plus opcode/func. All are 0 while rst is high.
- Reset: state=FETCH, retired=0. The first request is issued in the cycle after rst deasserts.
- Reset mid-instruction (including a pending memory wait) aborts it: outputs go to 0 in the same cycle and the instruction is not counted.
- Zero-wait latencies: R/I-ALU 4, lw 5, sw 4, branch/j/jal/jr 3, illegal 3 cycles. Each cycle mem_ready stays low adds one cycle.
- mem_read, mem_write and iord stay stable throughout a wait.

## Structure
- Package mips_ctrl_pkg: opcode and func constants, ALU op codes, state enum, pc_src/reg_dst/mem_to_reg encodings.
- Sub-module mips_alu_dec: combinational opcode/func → alu_op, signed_imm, instruction class, legal flag. Shared with the single-cycle controller's decode tables.

## Test plan
- add $3,$1,$2 with mem_ready tied high → FETCH,DECODE,EXEC_R,WB_R; WB_R has reg_write=1, reg_dst=01, alu_op=0010 in EXEC_R; retired 0→1.
- lw with mem_ready low for 2 cycles in both FETCH and MEM_RD → 9 cycles total; mem_read/iord stable while waiting; mem_to_reg=01 in MEM_WB.
- bne with alu_zero=0 → pc_en=1 in BRANCH; beq with alu_zero=0 → pc_en=0; retired increments in both cases.
- sltiu → alu_op=1110, signed_imm=1; ori → alu_op=0001, signed_imm=0.
- jal → JAL state drives reg_dst=10, mem_to_reg=10, pc_src=10, reg_write=1; jr (func 001000) → pc_src=11.
- opcode 111111, then rst asserted during a MEM_WR wait → illegal_instr pulses once with retired unchanged; after reset, retired=0, all outputs 0, then FETCH.
